uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter: the send-side counterpart of the design's UART receiver. It accepts 7-bit words through a valid/ready handshake into a small FIFO and serializes them LSB-first on `tx`, one bit per `baud_clk` cycle, with start/stop framing. Flow control uses `cts`. It sits between the core's result logic and the external serial line.

## Interface
- `DATA_BITS`, 7, data bits per frame.
- `STOP_BITS`, 1, stop-bit cycles per frame; legal values 1–2.
- `FIFO_DEPTH`, 4, transmit FIFO entries; a power of 2, at least 2.
- `rst` input 1: reset, asynchronous, active-high.
- `baud_clk` input 1: clock; one cycle = one bit time.
- `data_in` input DATA_BITS: word to send.
- `data_in_valid` input 1: `data_in` is valid this cycle.
- `data_in_ready` output 1: FIFO can accept a word; equals (count != FIFO_DEPTH).
- `cts` input 1: clear-to-send, active-high; the far end can receive.
- `tx` output 1: serial line, idle high; registered.
- `tx_buffer_empty` output 1: FIFO count == 0.
- `busy` output 1: FSM not in IDLE.

## Operation
- Push: on a `baud_clk` edge where `data_in_valid && data_in_ready`, `data_in` is written at the write pointer and the count increments.
- Valid while not ready: the word is dropped silently and nothing is stored. Upstream must hold the word until ready.
- FIFO: circular buffer with log2(FIFO_DEPTH)-bit read and write pointers. Pointers wrap naturally. The count is a separate register of log2(FIFO_DEPTH)+1 bits.
- A simultaneous push and pop leaves the count unchanged. Both pointers advance.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE: `tx`=1. If the count is nonzero and `cts`=1, the FSM pops the head word into the shift register, drives `tx`=0 and moves to START.
- START → DATA: `tx` = shift[0], then shift right. The bit counter starts at 0.
- DATA: each cycle outputs the next bit and increments the bit counter. After DATA_BITS bits have been driven, the FSM goes to PARITY if enabled, otherwise to STOP, and drives the corresponding bit (`tx`=1 for STOP).
- STOP: holds `tx`=1 for STOP_BITS cycles in total.
  - On the last stop cycle's exit edge, if the count is nonzero and `cts`=1, the FSM pops and goes directly to START with `tx`=0. Frames are sent back-to-back with no idle gap.
  - Otherwise the FSM goes to IDLE.
- `cts` is sampled only at the frame-start decision. Deasserting `cts` mid-frame does not abort the frame. It only blocks the next one.
- Reset, including mid-frame:
  - `tx`=1, `busy`=0, `data_in_ready`=1, `tx_buffer_empty`=1.
  - FSM=IDLE; pointers, count and bit counter = 0.
  - FIFO contents are discarded. A partial frame is truncated and the line returns high immediately.

## Timing
- Frame length is exactly 1 + DATA_BITS + P + STOP_BITS cycles, where P = 1 with parity enabled, otherwise 0. The default frame is 9 cycles.
- Latency: a word accepted at edge k into an empty FIFO with the FSM idle and `cts`=1 is popped at edge k+1. `tx` falls after edge k+1.
- `data_in_ready` and `tx_buffer_empty` reflect the count after each edge. A pop at edge k makes ready high after edge k.
- Full FIFO: ready stays low until the next pop.
- Empty FIFO with `cts`=1: the FSM stays in IDLE and `tx` stays 1.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: the PARITY state is compiled in. One even-parity bit follows the last data bit; its value is the XOR of all data bits. The frame grows by one cycle.
  - Undefined: there is no PARITY state and no parity logic. STOP immediately follows DATA.

## Test plan
- Reset, then one word: push 7'h55 with `cts`=1. Required `tx` per cycle from edge k+1: 0,1,0,1,0,1,0,1,1, then idle 1. `busy` is high for exactly 9 cycles.
- Parity build: push 7'h07, which has three ones. Required `tx` is 0,1,1,1,0,0,0,0,1(parity),1. With 7'h55 the parity bit is 0.
- Back-to-back frames: push 7'h01, 7'h7F, 7'h00, 7'h2A on consecutive cycles.
  - Frames must run contiguously with no extra high cycles; each start bit follows the previous stop bit immediately.
  - `data_in_ready` drops after the 4th push only if no pop has occurred yet.
- Full FIFO: hold `cts`=0 and push 5 words.
  - After 4 pushes `data_in_ready` goes to 0, the 5th word is dropped and `tx` stays 1.
  - Raising `cts` sends exactly 4 frames in order.
- Flow control mid-frame: drop `cts` during DATA of frame 1 with 2 words queued. Frame 1 must complete, `tx` then holds 1, and frame 2 starts 1 cycle after `cts` rises.
- Async reset mid-frame: assert `rst` during data bit 3. `tx` must go to 1 without waiting for a clock edge, `tx_buffer_empty`=1 and `busy`=0. After release, no stale frame is sent.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready push into a small FIFO, LSB-first serialisation on tx
// with start/stop framing and cts flow control. Define UART_TX_PARITY_EN for an even-parity bit.
`timescale 1ns/1ps

module uart_tx #(
    parameter int unsigned DATA_BITS  = 7,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 rst,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    input  logic                 cts,
    output logic                 tx,
    output logic                 tx_buffer_empty,
    output logic                 busy
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic start_ok;

    assign data_in_ready   = (count_q != CNT_W'(FIFO_DEPTH));
    assign tx_buffer_empty = (count_q == '0);
    assign tx              = tx_q;
    assign busy            = busy_q;

    assign push     = data_in_valid && data_in_ready;
    assign start_ok = (count_q != '0) && cts;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (start_ok) begin
                    pop     = 1'b1;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                tx_d      = shift_q[0];
                shift_d   = shift_q >> 1;
                bit_cnt_d = '0;
                state_d   = DATA;
            end
            DATA: begin
                // bit_cnt_q holds the index of the bit currently on the line
                if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    tx_d      = parity_q;
                    state_d   = PARITY;
`else
                    tx_d      = 1'b1;
                    state_d   = STOP;
`endif
                end else begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d      = 1'b1;
                bit_cnt_d = '0;
                state_d   = STOP;
            end
`endif
            STOP: begin
                if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                    if (start_ok) begin
                        pop     = 1'b1;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    tx_d      = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase

        // Both frame-start paths (IDLE and back-to-back from STOP) load the head word here.
        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            parity_d = ^mem_q[rd_ptr_q];
`endif
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Storage needs no reset: pointers and count alone define what is valid.
    always_ff @(posedge baud_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: single frame, back-to-back, full FIFO,
// cts flow control and asynchronous reset mid-frame.
`timescale 1ns/1ps

module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int FL = 10;
`else
    localparam int FL = 9;
`endif

    logic       rst;
    logic       baud_clk;
    logic [6:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       cts;
    logic       tx;
    logic       tx_buffer_empty;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    uart_tx #(.DATA_BITS(7), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .rst            (rst),
        .baud_clk       (baud_clk),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .cts            (cts),
        .tx             (tx),
        .tx_buffer_empty(tx_buffer_empty),
        .busy           (busy)
    );

    initial begin
        baud_clk = 1'b0;
        forever #5 baud_clk = ~baud_clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask

    // Expected line value i cycles into a frame carrying w.
    function automatic logic frame_bit(input logic [6:0] w, input int i);
        if (i == 0) return 1'b0;
        if (i <= 7) return w[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 8) return ^w;
`endif
        return 1'b1;
    endfunction

    logic [9:0] exp55;
    logic [6:0] words [4];

    initial begin
`ifdef UART_TX_PARITY_EN
        exp55 = 10'h2AA;
`else
        exp55 = 10'h1AA;
`endif
        rst = 1'b1; cts = 1'b1; data_in = '0; data_in_valid = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", data_in_ready, 1);
        check("rst_empty", tx_buffer_empty, 1);
        rst = 1'b0;
        tick();
        check("idle_empty_tx", tx, 1);
        check("idle_empty_busy", busy, 0);

        // Single frame 7'h55
        data_in = 7'h55; data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        check("w55_after_push_tx", tx, 1);
        check("w55_after_push_empty", tx_buffer_empty, 0);
        for (int i = 0; i < FL; i++) begin
            tick();
            check($sformatf("w55_tx_%0d", i), tx, exp55[i]);
            check($sformatf("w55_busy_%0d", i), busy, 1);
        end
        tick();
        check("w55_end_tx", tx, 1);
        check("w55_end_busy", busy, 0);
        check("w55_end_empty", tx_buffer_empty, 1);

        // Back-to-back frames
        words[0] = 7'h01; words[1] = 7'h7F; words[2] = 7'h00; words[3] = 7'h2A;
        data_in = words[0]; data_in_valid = 1'b1;
        tick();
        check("b2b_ready_0", data_in_ready, 1);
        for (int p = 1; p < 4; p++) begin
            data_in = words[p];
            tick();
            check($sformatf("b2b_ready_%0d", p), data_in_ready, 1);
            check($sformatf("b2b_tx_%0d", p - 1), tx, frame_bit(words[0], p - 1));
        end
        data_in_valid = 1'b0;
        for (int i = 3; i < 4 * FL; i++) begin
            tick();
            check($sformatf("b2b_tx_%0d", i), tx, frame_bit(words[i / FL], i % FL));
            check($sformatf("b2b_busy_%0d", i), busy, 1);
        end
        tick();
        check("b2b_end_tx", tx, 1);
        check("b2b_end_busy", busy, 0);
        check("b2b_end_empty", tx_buffer_empty, 1);

        // Full FIFO with cts low
        cts = 1'b0;
        words[0] = 7'h11; words[1] = 7'h22; words[2] = 7'h33; words[3] = 7'h44;
        data_in_valid = 1'b1;
        for (int p = 0; p < 4; p++) begin
            data_in = words[p];
            tick();
            check($sformatf("full_ready_%0d", p), data_in_ready, (p < 3) ? 1 : 0);
            check($sformatf("full_tx_%0d", p), tx, 1);
        end
        data_in = 7'h55;
        tick();
        data_in_valid = 1'b0;
        check("full_drop_ready", data_in_ready, 0);
        check("full_drop_tx", tx, 1);
        check("full_drop_busy", busy, 0);
        cts = 1'b1;
        for (int i = 0; i < 4 * FL; i++) begin
            tick();
            check($sformatf("full_frame_tx_%0d", i), tx, frame_bit(words[i / FL], i % FL));
            if (i == 0) check("full_ready_after_pop", data_in_ready, 1);
        end
        tick();
        check("full_end_tx", tx, 1);
        check("full_end_empty", tx_buffer_empty, 1);

        // cts dropped mid-frame
        words[0] = 7'h35; words[1] = 7'h4C;
        data_in = words[0]; data_in_valid = 1'b1;
        tick();
        data_in = words[1];
        tick();
        data_in_valid = 1'b0;
        check("cts_f1_tx_0", tx, frame_bit(words[0], 0));
        tick();
        check("cts_f1_tx_1", tx, frame_bit(words[0], 1));
        cts = 1'b0;
        for (int i = 2; i < FL; i++) begin
            tick();
            check($sformatf("cts_f1_tx_%0d", i), tx, frame_bit(words[0], i));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("cts_hold_tx_%0d", i), tx, 1);
            check($sformatf("cts_hold_busy_%0d", i), busy, 0);
            check($sformatf("cts_hold_empty_%0d", i), tx_buffer_empty, 0);
        end
        cts = 1'b1;
        for (int i = 0; i < FL; i++) begin
            tick();
            check($sformatf("cts_f2_tx_%0d", i), tx, frame_bit(words[1], i));
        end
        tick();
        check("cts_end_tx", tx, 1);
        check("cts_end_empty", tx_buffer_empty, 1);

        // Asynchronous reset during data bit 3
        data_in = 7'h00; data_in_valid = 1'b1;
        tick();
        tick();
        data_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("arst_pre_tx", tx, 0);
        check("arst_pre_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_tx", tx, 1);
        check("arst_busy", busy, 0);
        check("arst_empty", tx_buffer_empty, 1);
        check("arst_ready", data_in_ready, 1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("arst_post_tx_%0d", i), tx, 1);
            check($sformatf("arst_post_busy_%0d", i), busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
